// File: rtl/instr_seq_pkg.sv
// Shared constants for the instruction loader/sequencer.
// State codes, address map and control-word bit positions.
package instr_seq_pkg;

  localparam logic [8:0] CTRL_ADDR = 9'h1FF;
  localparam logic [8:0] RSVD_ADDR = 9'h1FE;
  localparam logic [7:0] LAST_SLOT = 8'd254;
  localparam logic [7:0] END_OPCODE = 8'hFF;

  localparam int START_BIT   = 0;
  localparam int IRQ_CLR_BIT = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/instr_seq_ctrl_ram.sv
// Single-port instruction store, synchronous read.
// Each 32-bit half has its own write enable.
module instr_ram #(
  parameter int AW = 8,
  parameter int HW = 32
) (
  input  logic          clk,
  input  logic          we_lo,
  input  logic          we_hi,
  input  logic [AW-1:0] addr,
  input  logic [HW-1:0] wdata,
  output logic [2*HW-1:0] rdata
);

  logic [2*HW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_lo) mem[addr][HW-1:0] <= wdata;
    if (we_hi) mem[addr][2*HW-1:HW] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// CPU-loaded instruction store with an in-order
// fetch/issue sequencer and a finish interrupt.
module instr_seq_ctrl
  import instr_seq_pkg::*;
#(
  parameter int INSTR_NUM_BIT = 8,
  parameter int BUS_W         = 32,
  parameter int INSTR_W       = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     CPU_instruction_valid,
  input  logic [INSTR_NUM_BIT:0]   CPU_instruction_addr,
  input  logic [BUS_W-1:0]         CPU_instruction_data,
  output logic                     CPU_instruction_irq,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [INSTR_W-1:0]       issue_instr,
  output logic [INSTR_NUM_BIT-1:0] issue_pc,
  input  logic                     dp_busy,
  output logic                     busy
);

  logic [2:0]               state;
  logic [INSTR_NUM_BIT-1:0] pc;
  logic                     irq;
  logic                     idle_st;
  logic                     ctrl_wr;
  logic                     store_wr;
  logic                     start;
  logic                     irq_clr;
  logic                     is_end;
  logic [INSTR_NUM_BIT-1:0] ram_addr;
  logic [INSTR_W-1:0]       rdata;

  assign idle_st = (state == S_IDLE) || (state == S_DONE);
  assign ctrl_wr = CPU_instruction_valid &&
                   (CPU_instruction_addr == CTRL_ADDR);
  assign store_wr = CPU_instruction_valid && idle_st &&
                    (CPU_instruction_addr != CTRL_ADDR) &&
                    (CPU_instruction_addr != RSVD_ADDR);
  assign start   = ctrl_wr && idle_st &&
                   CPU_instruction_data[START_BIT];
  assign irq_clr = ctrl_wr && CPU_instruction_data[IRQ_CLR_BIT];
  assign is_end  = rdata[INSTR_W-1 -: 8] == END_OPCODE;

  // Bus owns the RAM port only while the sequencer is parked.
  assign ram_addr = idle_st ? CPU_instruction_addr[INSTR_NUM_BIT:1] : pc;

  instr_ram #(
    .AW (INSTR_NUM_BIT),
    .HW (BUS_W)
  ) u_ram (
    .clk   (clk),
    .we_lo (store_wr && !CPU_instruction_addr[0]),
    .we_hi (store_wr && CPU_instruction_addr[0]),
    .addr  (ram_addr),
    .wdata (CPU_instruction_data),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      irq         <= 1'b0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      issue_pc    <= '0;
    end else begin
      if (irq_clr || start) irq <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (is_end) begin
            state <= S_DRAIN;
          end else begin
            issue_instr <= rdata;
            issue_pc    <= pc;
            issue_valid <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (pc == LAST_SLOT) begin
              state <= S_DRAIN;
            end else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          if (!dp_busy) begin
            state <= S_DONE;
            irq   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy                = !idle_st;
  assign CPU_instruction_irq = irq;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl: load, run,
// backpressure, END, full store, busy drops, reset.
module tb_instr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic        irq;
  logic        issue_valid;
  logic        issue_ready = 1'b1;
  logic [63:0] issue_instr;
  logic [7:0]  issue_pc;
  logic        dp_busy = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] P0 = 64'h0000_0001_0000_0002;
  localparam logic [63:0] P1 = 64'h0100_0000_0000_0003;
  localparam logic [63:0] PE = 64'hFF00_0000_0000_0000;

  instr_seq_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .CPU_instruction_valid (cpu_valid),
    .CPU_instruction_addr  (cpu_addr),
    .CPU_instruction_data  (cpu_data),
    .CPU_instruction_irq   (irq),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .issue_instr           (issue_instr),
    .issue_pc              (issue_pc),
    .dp_busy               (dp_busy),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [8:0] a, input logic [31:0] d);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_data  = d;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic load_slot(input int s, input logic [63:0] v);
    logic [7:0] sl;
    sl = s[7:0];
    bus_wr({sl, 1'b0}, v[31:0]);
    bus_wr({sl, 1'b1}, v[63:32]);
  endtask

  function automatic logic [63:0] fill_val(input int s);
    return {8'h10, 16'h0, s[7:0], 32'hC0DE_0000 | 32'(s)};
  endfunction

  // Counts handshakes until irq; checks pc order and fill data.
  task automatic run(input int budget, output int n,
                     output int bad, output logic [7:0] last);
    n = 0;
    bad = 0;
    last = '0;
    for (int c = 0; c < budget; c++) begin
      if (issue_valid && issue_ready) begin
        if (issue_pc !== n[7:0] || issue_instr !== fill_val(n))
          bad++;
        last = issue_pc;
        n++;
      end
      if (irq) break;
      tick();
    end
  endtask

  int n_iss;
  int n_bad;
  logic [7:0] last_pc;

  initial begin
    tick();
    tick();
    chk("rst_valid", issue_valid, 0);
    chk("rst_instr", issue_instr, 0);
    chk("rst_pc", issue_pc, 0);
    chk("rst_irq", irq, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // 1: basic two-instruction program
    load_slot(0, P0);
    load_slot(1, P1);
    load_slot(2, PE);
    dp_busy = 1'b1;
    bus_wr(9'h1FF, 32'h1);
    chk("t1_busy", busy, 1);
    chk("t1_v_fetch", issue_valid, 0);
    tick();
    chk("t1_v_wait", issue_valid, 0);
    tick();
    chk("t1_v0", issue_valid, 1);
    chk("t1_pc0", issue_pc, 0);
    chk("t1_i0", issue_instr, P0);
    tick();
    chk("t1_v_drop", issue_valid, 0);
    tick();
    tick();
    chk("t1_v1", issue_valid, 1);
    chk("t1_pc1", issue_pc, 1);
    chk("t1_i1", issue_instr, P1);
    tick();
    tick();
    tick();
    chk("t1_end_not_issued", issue_valid, 0);
    tick();
    tick();
    chk("t1_drain_irq", irq, 0);
    chk("t1_drain_busy", busy, 1);
    dp_busy = 1'b0;
    tick();
    chk("t1_irq", irq, 1);
    chk("t1_done_busy", busy, 0);

    // 2: backpressure on slot1
    bus_wr(9'h1FF, 32'h1);
    chk("t2_start_clr_irq", irq, 0);
    tick();
    tick();
    chk("t2_pc0", issue_pc, 0);
    tick();
    issue_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_v", issue_valid, 1);
      chk("t2_hold_pc", issue_pc, 1);
      chk("t2_hold_i", issue_instr, P1);
      tick();
    end
    chk("t2_still_v", issue_valid, 1);
    issue_ready = 1'b1;
    tick();
    chk("t2_accepted", issue_valid, 0);
    run(50, n_iss, n_bad, last_pc);
    chk("t2_no_reissue", n_iss, 0);
    chk("t2_irq", irq, 1);

    // 3: END in slot0
    load_slot(0, PE);
    bus_wr(9'h1FF, 32'h1);
    chk("t3_irq_t1", irq, 0);
    tick();
    chk("t3_irq_t2", irq, 0);
    tick();
    chk("t3_irq_t3", irq, 0);
    chk("t3_no_valid", issue_valid, 0);
    tick();
    chk("t3_irq_t4", irq, 1);
    bus_wr(9'h1FF, 32'h2);
    chk("t3_irq_clr", irq, 0);
    chk("t3_busy", busy, 0);

    // 4: full store, reserved address
    for (int s = 0; s < 255; s++) load_slot(s, fill_val(s));
    bus_wr(9'h1FE, 32'h3);
    chk("t4_rsvd_busy", busy, 0);
    chk("t4_rsvd_irq", irq, 0);
    bus_wr(9'h1FF, 32'h1);
    run(2000, n_iss, n_bad, last_pc);
    chk("t4_count", n_iss, 255);
    chk("t4_bad", n_bad, 0);
    chk("t4_last_pc", last_pc, 254);
    chk("t4_irq", irq, 1);

    // 5: writes while busy are dropped
    load_slot(5, PE);
    bus_wr(9'h1FF, 32'h1);
    bus_wr(9'h006, 32'hDEAD_BEEF);
    bus_wr(9'h1FF, 32'h1);
    run(200, n_iss, n_bad, last_pc);
    chk("t5_count", n_iss, 5);
    chk("t5_bad", n_bad, 0);
    bus_wr(9'h1FF, 32'h1);
    run(200, n_iss, n_bad, last_pc);
    chk("t5_rerun_count", n_iss, 5);
    chk("t5_rerun_bad", n_bad, 0);
    chk("t5_irq", irq, 1);

    // 6: reset while in ISSUE
    issue_ready = 1'b0;
    bus_wr(9'h1FF, 32'h1);
    tick();
    tick();
    chk("t6_in_issue", issue_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_valid", issue_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_irq", irq, 0);
    chk("t6_pc", issue_pc, 0);
    rst_n = 1'b1;
    issue_ready = 1'b1;
    bus_wr(9'h1FF, 32'h1);
    run(200, n_iss, n_bad, last_pc);
    chk("t6_count", n_iss, 5);
    chk("t6_bad", n_bad, 0);
    chk("t6_irq_end", irq, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
